dct_2d_ctrl: RTL and testbench



---
 rtl/dct_pkg.sv | 20 ++
 rtl/dct_vld_pipe.sv | 33 +++
 rtl/dct_2d_ctrl.sv | 117 +++++++++++
 tb/tb_dct_2d_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared types and constants for the 16x16 2D DCT controller
package dct_pkg;
  localparam int BLK_N = 16;
  localparam int IDX_W = 4;

  // Default latencies, kept in step with the DCT datapath build
  localparam int DEF_MEM_LAT = 1;
  localparam int DEF_ROW_LAT = 2;
  localparam int DEF_TB_LAT  = 1;
  localparam int DEF_COL_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW_RD,
    S_ROW_WAIT,
    S_COL_RD,
    S_COL_WAIT,
    S_DONE
  } state_t;
endpackage

// File: rtl/dct_vld_pipe.sv
// rtl/dct_vld_pipe.sv - fixed-depth delay line for a {valid, idx} pair
module dct_vld_pipe
  import dct_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);
  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0][IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_idx <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_idx[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_idx = r_idx[DEPTH-1];
endmodule

// File: rtl/dct_2d_ctrl.sv
// rtl/dct_2d_ctrl.sv - block sequencer: row reads, transpose, column reads, output writes
module dct_2d_ctrl
  import dct_pkg::*;
#(
  parameter int NUM_BLOCKS = 32,
  parameter int ADDR_W     = 9,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int ROW_LAT    = DEF_ROW_LAT,
  parameter int TB_LAT     = DEF_TB_LAT,
  parameter int COL_LAT    = DEF_COL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-5:0] blk_idx,
  output logic              mem_in_ren,
  output logic [ADDR_W-1:0] mem_in_addr,
  output logic              row_valid,
  output logic              tb_wen,
  output logic [3:0]        tb_waddr,
  output logic              tb_ren,
  output logic [3:0]        tb_raddr,
  output logic              col_valid,
  output logic              mem_out_wen,
  output logic [ADDR_W-1:0] mem_out_addr
);
  localparam int BLK_W = ADDR_W - 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_N - 1);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;
  logic [BLK_W-1:0] r_blk, w_blk_nxt;
  logic [IDX_W-1:0] w_rv_idx, w_cv_idx, w_mo_idx, w_mi_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_blk   <= w_blk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_blk_nxt   = r_blk;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ROW_RD;
          w_cnt_nxt   = '0;
          w_blk_nxt   = '0;
        end
      end
      S_ROW_RD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_IDX) w_state_nxt = S_ROW_WAIT;
      end
      S_ROW_WAIT: begin
        if (tb_wen && tb_waddr == LAST_IDX) w_state_nxt = S_COL_RD;
      end
      S_COL_RD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_IDX) w_state_nxt = S_COL_WAIT;
      end
      S_COL_WAIT: begin
        // The last column write drains the block; only then may the next block start
        if (mem_out_wen && w_mo_idx == LAST_IDX) begin
          if (r_blk == BLK_W'(NUM_BLOCKS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ROW_RD;
            w_blk_nxt   = r_blk + 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign blk_idx     = r_blk;
  assign mem_in_ren  = (r_state == S_ROW_RD);
  assign tb_ren      = (r_state == S_COL_RD);
  assign w_mi_idx    = mem_in_ren ? r_cnt : '0;
  assign mem_in_addr = mem_in_ren ? {r_blk, r_cnt} : '0;
  assign tb_raddr    = tb_ren ? r_cnt : '0;
  assign mem_out_addr = mem_out_wen ? {r_blk, w_mo_idx} : '0;

  dct_vld_pipe #(.DEPTH(MEM_LAT)) u_mem_pipe (
    .clk(clk), .rst(rst), .i_vld(mem_in_ren), .i_idx(w_mi_idx),
    .o_vld(row_valid), .o_idx(w_rv_idx)
  );

  dct_vld_pipe #(.DEPTH(ROW_LAT)) u_row_pipe (
    .clk(clk), .rst(rst), .i_vld(row_valid), .i_idx(w_rv_idx),
    .o_vld(tb_wen), .o_idx(tb_waddr)
  );

  dct_vld_pipe #(.DEPTH(TB_LAT)) u_tb_pipe (
    .clk(clk), .rst(rst), .i_vld(tb_ren), .i_idx(tb_raddr),
    .o_vld(col_valid), .o_idx(w_cv_idx)
  );

  dct_vld_pipe #(.DEPTH(COL_LAT)) u_col_pipe (
    .clk(clk), .rst(rst), .i_vld(col_valid), .i_idx(w_cv_idx),
    .o_vld(mem_out_wen), .o_idx(w_mo_idx)
  );
endmodule

// File: tb/tb_dct_2d_ctrl.sv
// tb/tb_dct_2d_ctrl.sv - scoreboard bench for dct_2d_ctrl (default and stretched latencies)
module tb_dct_2d_ctrl;
  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  logic       clk = 1'b0;
  logic [1:0] rst, start;
  logic [1:0] bsy, dn, mi_ren, rv, tw_en, tr_en, cv, mo_en;
  logic [4:0] blk     [2];
  logic [8:0] mi_addr [2];
  logic [8:0] mo_addr [2];
  logic [3:0] tw_addr [2];
  logic [3:0] tr_addr [2];

  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;
  int    busy_lo [2] = '{1, 1};
  int    busy_hi [2] = '{0, 0};
  ev_t   sb [2][7][$];
  string sname [7] = '{"mem_in", "row_valid", "tb_w", "tb_r", "col_valid", "mem_out", "done"};
  int    base;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct_2d_ctrl #(.NUM_BLOCKS(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(bsy[0]), .done(dn[0]),
    .blk_idx(blk[0]), .mem_in_ren(mi_ren[0]), .mem_in_addr(mi_addr[0]),
    .row_valid(rv[0]), .tb_wen(tw_en[0]), .tb_waddr(tw_addr[0]),
    .tb_ren(tr_en[0]), .tb_raddr(tr_addr[0]), .col_valid(cv[0]),
    .mem_out_wen(mo_en[0]), .mem_out_addr(mo_addr[0])
  );

  dct_2d_ctrl #(.NUM_BLOCKS(1), .ROW_LAT(4), .COL_LAT(5)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(bsy[1]), .done(dn[1]),
    .blk_idx(blk[1]), .mem_in_ren(mi_ren[1]), .mem_in_addr(mi_addr[1]),
    .row_valid(rv[1]), .tb_wen(tw_en[1]), .tb_waddr(tw_addr[1]),
    .tb_ren(tr_en[1]), .tb_raddr(tr_addr[1]), .col_valid(cv[1]),
    .mem_out_wen(mo_en[1]), .mem_out_addr(mo_addr[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
  endtask

  // Expected schedule of every enable, derived from the phase lengths and latencies
  task automatic push_run(input int d, input int b0, input int nblk,
                          input int ml, input int rl, input int tl, input int cl);
    int c;
    int t0;
    c = 32 + ml + rl + tl + cl;
    for (int b = 0; b < nblk; b++) begin
      t0 = b0 + 1 + b * c;
      for (int r = 0; r < 16; r++) begin
        sb[d][0].push_back('{t0 + r, b * 16 + r});
        sb[d][1].push_back('{t0 + ml + r, 0});
        sb[d][2].push_back('{t0 + ml + rl + r, r});
        sb[d][3].push_back('{t0 + 16 + ml + rl + r, r});
        sb[d][4].push_back('{t0 + 16 + ml + rl + tl + r, 0});
        sb[d][5].push_back('{t0 + 16 + ml + rl + tl + cl + r, b * 16 + r});
      end
    end
    sb[d][6].push_back('{b0 + 1 + nblk * c, 0});
    busy_lo[d] = b0 + 1;
    busy_hi[d] = b0 + nblk * c;
  endtask

  task automatic step(input int d, input int s, input logic en, input int addr);
    bit  exp_en;
    ev_t ev;
    exp_en = (sb[d][s].size() > 0) && (sb[d][s][0].cyc == cyc);
    check($sformatf("%s_en%0d", sname[s], d), int'(en), int'(exp_en));
    if (exp_en) begin
      ev = sb[d][s].pop_front();
      if (en && (s == 0 || s == 2 || s == 3 || s == 5))
        check($sformatf("%s_addr%0d", sname[s], d), addr, ev.addr);
      if (en && s == 0)
        check($sformatf("blk_idx%0d", d), int'(blk[d]), ev.addr / 16);
    end
  endtask

  task automatic flush_after(input int d, input int limit);
    for (int s = 0; s < 7; s++)
      while (sb[d][s].size() > 0 && sb[d][s][$].cyc > limit) void'(sb[d][s].pop_back());
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse(input int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      step(d, 0, mi_ren[d], int'(mi_addr[d]));
      step(d, 1, rv[d], 0);
      step(d, 2, tw_en[d], int'(tw_addr[d]));
      step(d, 3, tr_en[d], int'(tr_addr[d]));
      step(d, 4, cv[d], 0);
      step(d, 5, mo_en[d], int'(mo_addr[d]));
      step(d, 6, dn[d], 0);
      check($sformatf("busy%0d", d), int'(bsy[d]), int'(cyc >= busy_lo[d] && cyc <= busy_hi[d]));
      check($sformatf("tb_rw_overlap%0d", d), int'(tw_en[d] & tr_en[d]), 0);
    end
  end

  initial begin
    rst   = 2'b11;
    start = 2'b00;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    for (int d = 0; d < 2; d++) check($sformatf("blk_rst%0d", d), int'(blk[d]), 0);
    repeat (2) @(negedge clk);

    // Two-block run with stray starts at cycles 5, 20 and in DONE
    base = cyc;
    push_run(0, base, 2, 1, 2, 1, 2);
    pulse(0);
    wait_until(base + 5);  pulse(0);
    wait_until(base + 20); pulse(0);
    wait_until(base + 77); pulse(0);

    // Start one cycle after DONE, then abort in COL_RD
    base = cyc;
    push_run(0, base, 2, 1, 2, 1, 2);
    pulse(0);
    wait_until(base + 25);
    rst[0] = 1'b1;
    flush_after(0, base + 25);
    busy_hi[0] = base + 25;
    @(negedge clk);
    rst[0] = 1'b0;
    check("blk_abort0", int'(blk[0]), 0);
    repeat (10) @(negedge clk);

    base = cyc;
    push_run(0, base, 2, 1, 2, 1, 2);
    pulse(0);
    wait_until(base + 82);

    // Stretched row/column latencies on the single-block instance
    base = cyc;
    push_run(1, base, 1, 1, 4, 1, 5);
    pulse(1);
    wait_until(base + 50);

    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 7; s++)
        check($sformatf("%s_drain%0d", sname[s], d), sb[d][s].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
